i2c_master_byte: RTL and testbench

- Byte-level I2C master engine, sitting directly upstream of the bus pins and driven by the project's transaction sequencer.
- Accepts one command at a time: START, STOP, WRITE byte or READ byte.
- Generates SCL and SDA as open-drain controls, samples SDA, and reports the ACK or read data with a one-cycle done pulse.

---
 rtl/i2c_pkg.sv | 39 +++
 rtl/i2c_clk_div.sv | 37 +++
 rtl/i2c_master_byte.sv | 174 +++++++++++++++++
 tb/tb_i2c_master_byte.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C master engine.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_READ  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int unsigned BIT_W = 4;
    localparam logic [BIT_W-1:0] LAST_DATA_BIT = 4'd8;

    // Per-command payload captured on accept; data doubles as the read shift register.
    typedef struct packed {
        logic [7:0] data;
        logic       rd_ack;
    } xfer_t;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period divider: counts 0..CLK_DIV-1 while enabled and flags the wrap cycle.
module i2c_clk_div #(
    parameter int unsigned CLK_DIV = 250,
    parameter int unsigned DIV_W   = $clog2(CLK_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_c = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick_c ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: executes one START/STOP/WRITE/READ command on open-drain SCL/SDA controls.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250,
    parameter int unsigned DIV_W   = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_ack_in,
    output logic [7:0] rd_data,
    output logic       ack_out,
    output logic       done,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i
);

    state_e           state_q, state_d;
    quarter_e         qtr_q, qtr_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    xfer_t            xfer_q, xfer_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             ack_out_q, ack_out_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cmd_ready_q, cmd_ready_d;

    logic             tick_c;
    logic             div_clr_c;
    logic [BIT_W-1:0] last_bit_c;
    logic [2:0]       sda_idx_c;
    logic             scl_mid_c;

    i2c_clk_div #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .clr    (div_clr_c),
        .en     (busy_q),
        .tick_c (tick_c)
    );

    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        xfer_d      = xfer_q;
        rd_data_d   = rd_data_q;
        ack_out_d   = ack_out_q;
        scl_d       = scl_q;
        sda_d       = sda_q;
        div_clr_c   = 1'b0;
        last_bit_c  = (state_q == ST_WRITE || state_q == ST_READ) ? LAST_DATA_BIT : '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    div_clr_c     = 1'b1;
                    qtr_d         = Q0;
                    bit_d         = '0;
                    xfer_d.data   = wr_data;
                    xfer_d.rd_ack = rd_ack_in;
                    case (cmd_e'(cmd))
                        CMD_START: state_d = ST_START;
                        CMD_STOP:  state_d = ST_STOP;
                        CMD_WRITE: state_d = ST_WRITE;
                        CMD_READ:  state_d = ST_READ;
                    endcase
                end
            end
            ST_START, ST_STOP, ST_WRITE, ST_READ: begin
                if (tick_c) begin
                    // Slave data is sampled at the end of the SCL-high window.
                    if (qtr_q == Q2 && state_q == ST_WRITE && bit_q == LAST_DATA_BIT) begin
                        ack_out_d = sda_i;
                    end
                    if (qtr_q == Q2 && state_q == ST_READ && bit_q != LAST_DATA_BIT) begin
                        xfer_d.data = {xfer_q.data[6:0], sda_i};
                    end
                    if (qtr_q == Q3) begin
                        if (bit_q == last_bit_c) begin
                            state_d = ST_DONE;
                            if (state_q == ST_READ) begin
                                rd_data_d = xfer_q.data;
                            end
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                            qtr_d = Q0;
                        end
                    end else begin
                        qtr_d = quarter_e'(qtr_q + 2'd1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Line levels follow the position being entered so the registered pins align with the quarter.
        sda_idx_c = 3'(4'd7 - bit_d);
        scl_mid_c = (qtr_d == Q1) || (qtr_d == Q2);
        case (state_d)
            ST_START: begin
                scl_d = scl_mid_c;
                sda_d = (qtr_d == Q0) || (qtr_d == Q1);
            end
            ST_STOP: begin
                scl_d = (qtr_d != Q0);
                sda_d = (qtr_d == Q2) || (qtr_d == Q3);
            end
            ST_WRITE: begin
                scl_d = scl_mid_c;
                sda_d = (bit_d == LAST_DATA_BIT) ? I2C_NACK : xfer_d.data[sda_idx_c];
            end
            ST_READ: begin
                scl_d = scl_mid_c;
                sda_d = (bit_d == LAST_DATA_BIT) ? xfer_d.rd_ack : 1'b1;
            end
            default: ;
        endcase

        busy_d      = (state_d == ST_START) || (state_d == ST_STOP) ||
                      (state_d == ST_WRITE) || (state_d == ST_READ);
        done_d      = (state_d == ST_DONE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            qtr_q       <= Q0;
            bit_q       <= '0;
            xfer_q      <= '0;
            rd_data_q   <= '0;
            ack_out_q   <= I2C_ACK;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            xfer_q      <= xfer_d;
            rd_data_q   <= rd_data_d;
            ack_out_q   <= ack_out_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rd_data   = rd_data_q;
    assign ack_out   = ack_out_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign scl_o     = scl_q;
    assign sda_o     = sda_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Randomized bench for i2c_master_byte: two instances (quarter of 4 and of 2 cycles) against a quarter-table model.
module tb_i2c_master_byte;

    localparam int NU = 2;
    localparam int D0 = 4;
    localparam int D1 = 2;

    logic       clk = 1'b0;
    logic       rst       [NU];
    logic       cmd_valid [NU];
    logic       cmd_ready [NU];
    logic [1:0] cmd       [NU];
    logic [7:0] wr_data   [NU];
    logic       rd_ack_in [NU];
    logic [7:0] rd_data   [NU];
    logic       ack_out   [NU];
    logic       done      [NU];
    logic       busy      [NU];
    logic       scl_o     [NU];
    logic       sda_o     [NU];
    logic       sda_i     [NU];

    i2c_master_byte #(.CLK_DIV(D0)) dut0 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd(cmd[0]), .wr_data(wr_data[0]), .rd_ack_in(rd_ack_in[0]), .rd_data(rd_data[0]),
        .ack_out(ack_out[0]), .done(done[0]), .busy(busy[0]), .scl_o(scl_o[0]),
        .sda_o(sda_o[0]), .sda_i(sda_i[0])
    );

    i2c_master_byte #(.CLK_DIV(D1)) dut1 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd(cmd[1]), .wr_data(wr_data[1]), .rd_ack_in(rd_ack_in[1]), .rd_data(rd_data[1]),
        .ack_out(ack_out[1]), .done(done[1]), .busy(busy[1]), .scl_o(scl_o[1]),
        .sda_o(sda_o[1]), .sda_i(sda_i[1])
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errs   = 0;
    logic [7:0] model_rd  [NU];
    logic       model_ack [NU];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_of(input int u);
        return (u == 0) ? D0 : D1;
    endfunction

    function automatic int n_bits(input logic [1:0] c);
        return (c == 2'b10 || c == 2'b11) ? 9 : 1;
    endfunction

    // Expected {scl,sda} for a command at a given bit and quarter, straight from the waveform tables.
    function automatic logic [1:0] exp_lines(input logic [1:0] c, input int b, input int q,
                                             input logic [7:0] d, input logic ak);
        logic [1:0] start_tab [4];
        logic [1:0] stop_tab  [4];
        logic       scl_hi;
        start_tab = '{2'b01, 2'b11, 2'b10, 2'b00};
        stop_tab  = '{2'b00, 2'b10, 2'b11, 2'b11};
        scl_hi    = (q == 1) || (q == 2);
        case (c)
            2'b00:   return start_tab[q];
            2'b01:   return stop_tab[q];
            2'b10:   return {scl_hi, (b < 8) ? d[7-b] : 1'b1};
            default: return {scl_hi, (b < 8) ? 1'b1 : ak};
        endcase
    endfunction

    // Issue one command, drive the slave side, and compare every cycle against the model.
    task automatic run_cmd(input int u, input logic [1:0] c, input logic [7:0] d, input logic ak,
                           input logic [7:0] rbyte, input logic wack);
        int         dv, n, guard, bad, nbusy, b, q;
        logic [1:0] ln, hold;
        logic       exp_ack;
        dv    = div_of(u);
        n     = 4 * n_bits(c) * dv;
        guard = 0;
        while (cmd_ready[u] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_wait", 32'(guard < 200), 32'd1);
        cmd_valid[u] = 1'b1;
        cmd[u]       = c;
        wr_data[u]   = d;
        rd_ack_in[u] = ak;
        @(negedge clk);
        bad   = 0;
        nbusy = 0;
        for (int k = 0; k < n; k++) begin
            b = k / (4 * dv);
            q = (k / dv) % 4;
            // Inputs change after accept: they must have been captured, and a mid-command STOP is ignored.
            cmd_valid[u] = (k == n / 2);
            cmd[u]       = (k == n / 2) ? 2'b01 : 2'($urandom);
            wr_data[u]   = 8'($urandom);
            rd_ack_in[u] = 1'($urandom);
            if (c == 2'b11) begin
                if (b < 8 && (k % (4 * dv)) == 0) sda_i[u] = rbyte[7-b];
                else if (b == 8) sda_i[u] = 1'($urandom);
            end else if (c == 2'b10) begin
                sda_i[u] = (b == 8) ? wack : 1'($urandom);
            end
            ln      = exp_lines(c, b, q, d, ak);
            exp_ack = (c == 2'b10 && b == 8 && q == 3) ? wack : model_ack[u];
            if (busy[u] === 1'b1) nbusy++;
            if (busy[u] !== 1'b1 || done[u] !== 1'b0 || cmd_ready[u] !== 1'b0 ||
                {scl_o[u], sda_o[u]} !== ln || rd_data[u] !== model_rd[u] ||
                ack_out[u] !== exp_ack) begin
                if (bad == 0)
                    $display("  first deviation cmd=%0d bit=%0d q=%0d scl/sda=%b%b exp=%b busy=%b",
                             c, b, q, scl_o[u], sda_o[u], ln, busy[u]);
                bad++;
            end
            @(negedge clk);
        end
        cmd_valid[u] = 1'b0;
        if (c == 2'b10) model_ack[u] = wack;
        if (c == 2'b11) model_rd[u]  = rbyte;
        hold = exp_lines(c, n_bits(c) - 1, 3, d, ak);
        check_eq("trace_deviations", 32'(bad), 32'd0);
        check_eq("busy_cycles", 32'(nbusy), 32'(n));
        check_eq("busy_end", 32'(busy[u]), 32'd0);
        check_eq("done_pulse", 32'(done[u]), 32'd1);
        check_eq("ready_in_done", 32'(cmd_ready[u]), 32'd0);
        check_eq("rd_data", 32'(rd_data[u]), 32'(model_rd[u]));
        check_eq("ack_out", 32'(ack_out[u]), 32'(model_ack[u]));
        check_eq("lines_done", 32'({scl_o[u], sda_o[u]}), 32'(hold));
        @(negedge clk);
        check_eq("done_cleared", 32'(done[u]), 32'd0);
        check_eq("ready_back", 32'(cmd_ready[u]), 32'd1);
        check_eq("lines_hold", 32'({scl_o[u], sda_o[u]}), 32'(hold));
    endtask

    task automatic run_random(input int u, input int count);
        for (int i = 0; i < count; i++)
            run_cmd(u, 2'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    endtask

    // Asynchronous reset 50 cycles into a WRITE: lines release with no clock edge and no done follows.
    task automatic reset_mid_write(input int u);
        logic seen_done;
        cmd_valid[u] = 1'b1;
        cmd[u]       = 2'b10;
        wr_data[u]   = 8'h00;
        rd_ack_in[u] = 1'b0;
        @(negedge clk);
        cmd_valid[u] = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy[u]), 32'd1);
        check_eq("pre_rst_sda", 32'(sda_o[u]), 32'd0);
        #1 rst[u] = 1'b0;
        #1;
        model_rd[u]  = 8'h00;
        model_ack[u] = 1'b0;
        check_eq("rst_scl", 32'(scl_o[u]), 32'd1);
        check_eq("rst_sda", 32'(sda_o[u]), 32'd1);
        check_eq("rst_busy", 32'(busy[u]), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready[u]), 32'd1);
        check_eq("rst_ack_out", 32'(ack_out[u]), 32'd0);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done[u] === 1'b1) seen_done = 1'b1;
        end
        rst[u] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done[u] === 1'b1 || busy[u] === 1'b1) seen_done = 1'b1;
        end
        check_eq("no_done_after_rst", 32'(seen_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int u = 0; u < NU; u++) begin
            rst[u]       = 1'b0;
            cmd_valid[u] = 1'b0;
            cmd[u]       = 2'b00;
            wr_data[u]   = 8'h00;
            rd_ack_in[u] = 1'b0;
            sda_i[u]     = 1'b1;
            model_rd[u]  = 8'h00;
            model_ack[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            check_eq("reset_lines", 32'({scl_o[u], sda_o[u]}), 32'h3);
            check_eq("reset_busy_done", 32'({busy[u], done[u]}), 32'h0);
            check_eq("reset_ready", 32'(cmd_ready[u]), 32'd1);
            check_eq("reset_rd_ack", 32'({rd_data[u], ack_out[u]}), 32'h0);
            rst[u] = 1'b1;
        end
        @(negedge clk);

        run_cmd(0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_cmd(0, 2'b01, 8'h00, 1'b0, 8'h00, 1'b0);
        run_cmd(0, 2'b10, 8'hA5, 1'b0, 8'h00, 1'b0);
        run_cmd(0, 2'b10, 8'h3C, 1'b0, 8'h00, 1'b1);
        run_cmd(0, 2'b11, 8'h00, 1'b1, 8'h96, 1'b0);
        run_cmd(0, 2'b11, 8'h00, 1'b0, 8'($urandom), 1'b0);
        run_random(0, 8);
        reset_mid_write(0);
        run_cmd(0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_cmd(0, 2'b10, 8'($urandom), 1'b0, 8'h00, 1'($urandom));
        run_cmd(0, 2'b01, 8'h00, 1'b0, 8'h00, 1'b0);

        run_cmd(1, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_cmd(1, 2'b10, 8'($urandom), 1'b0, 8'h00, 1'($urandom));
        run_cmd(1, 2'b11, 8'h00, 1'($urandom), 8'($urandom), 1'b0);
        run_cmd(1, 2'b01, 8'h00, 1'b0, 8'h00, 1'b0);
        run_random(1, 6);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
